period_detector: RTL and testbench

Receive-side companion to the period-selectable enable generator. The block watches a single-cycle enable pulse stream `en` and measures the number of clock cycles between pulses. It recovers which 3-bit period code (`sw` setting) produced the stream and asserts `locked` once the period is stable. While locked, it counts received pulses on a 4-bit wrapping output `q`. It sits on the same clock as the generator and is used to self-check the generator in-system.

---
 rtl/period_detector.sv | 208 ++++++++++++++++++++
 tb/tb_period_detector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/period_detector.sv
// period_detector: measures the spacing of rising edges on an enable pulse
// stream, recovers the 3-bit period code that produced it, reports lock and
// counts pulses while locked.
module period_detector #(
  parameter int BASE_DIV = 4,
  parameter int LOCK_N   = 2,
  parameter int CNT_W    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [2:0] sw_det,
  output logic       locked,
  output logic       err,
  output logic [3:0] q
);

  localparam int               MAXP     = BASE_DIV * 128;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAXP + 1);
  localparam logic [4:0]       LOCK_TGT = 5'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    CAND  = 2'd2,
    LOCK  = 2'd3
  } state_t;

  // Returns {hit, code}: hit is set when p equals BASE_DIV<<code for some code.
  function automatic logic [3:0] code_match(input logic [CNT_W-1:0] p);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (p == (CNT_W'(BASE_DIV) << k)) begin
        r = {1'b1, 3'(k)};
      end
    end
    return r;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             en_q_r;
  logic [2:0]       cand_r, cand_nxt_s;
  logic [3:0]       mcnt_r, mcnt_nxt_s;
  logic [2:0]       sw_det_r, sw_det_nxt_s;
  logic             locked_r, locked_nxt_s;
  logic             err_r, err_nxt_s;
  logic [3:0]       q_r, q_nxt_s;

  logic             edge_s;
  logic [3:0]       match_s;
  logic             hit_s;
  logic [2:0]       code_s;
  logic             timeout_s;
  logic [4:0]       mcnt_inc_s;

  assign sw_det = sw_det_r;
  assign locked = locked_r;
  assign err    = err_r;
  assign q      = q_r;

  // Edge detect, period decode and timeout qualification.
  always_comb begin
    edge_s     = en & ~en_q_r;
    match_s    = code_match(cnt_r);
    hit_s      = match_s[3];
    code_s     = match_s[2:0];
    timeout_s  = (cnt_r == CNT_SAT) & ~edge_s;
    mcnt_inc_s = {1'b0, mcnt_r} + 5'd1;
  end

  // Interval counter: restart at 1 on an edge, otherwise count up and saturate.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (edge_s) begin
      cnt_nxt_s = CNT_W'(1);
    end else if (cnt_r != CNT_SAT) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Lock state machine: next state and next values of all registered outputs.
  always_comb begin
    state_nxt_s  = state_r;
    cand_nxt_s   = cand_r;
    mcnt_nxt_s   = mcnt_r;
    sw_det_nxt_s = sw_det_r;
    locked_nxt_s = locked_r;
    err_nxt_s    = 1'b0;
    q_nxt_s      = q_r;
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          state_nxt_s = FIRST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FIRST: begin
        if (edge_s) begin
          if (hit_s) begin
            cand_nxt_s = code_s;
            mcnt_nxt_s = 4'd1;
            if (LOCK_N <= 1) begin
              state_nxt_s  = LOCK;
              sw_det_nxt_s = code_s;
              locked_nxt_s = 1'b1;
              q_nxt_s      = 4'd0;
            end else begin
              state_nxt_s = CAND;
            end
          end else begin
            err_nxt_s = 1'b1;
          end
        end else if (timeout_s) begin
          err_nxt_s    = 1'b1;
          locked_nxt_s = 1'b0;
          state_nxt_s  = IDLE;
        end else begin
          state_nxt_s = FIRST;
        end
      end
      CAND: begin
        if (edge_s) begin
          if (hit_s && (code_s == cand_r)) begin
            mcnt_nxt_s = mcnt_inc_s[3:0];
            if (mcnt_inc_s >= LOCK_TGT) begin
              state_nxt_s  = LOCK;
              sw_det_nxt_s = cand_r;
              locked_nxt_s = 1'b1;
              q_nxt_s      = 4'd0;
            end else begin
              state_nxt_s = CAND;
            end
          end else if (hit_s) begin
            cand_nxt_s = code_s;
            mcnt_nxt_s = 4'd1;
          end else begin
            err_nxt_s   = 1'b1;
            state_nxt_s = FIRST;
          end
        end else if (timeout_s) begin
          err_nxt_s    = 1'b1;
          locked_nxt_s = 1'b0;
          state_nxt_s  = IDLE;
        end else begin
          state_nxt_s = CAND;
        end
      end
      LOCK: begin
        if (edge_s) begin
          if (hit_s && (code_s == sw_det_r)) begin
            q_nxt_s = q_r + 4'd1;
          end else begin
            err_nxt_s    = 1'b1;
            locked_nxt_s = 1'b0;
            if (hit_s) begin
              cand_nxt_s  = code_s;
              mcnt_nxt_s  = 4'd1;
              state_nxt_s = CAND;
            end else begin
              state_nxt_s = FIRST;
            end
          end
        end else if (timeout_s) begin
          err_nxt_s    = 1'b1;
          locked_nxt_s = 1'b0;
          state_nxt_s  = IDLE;
        end else begin
          state_nxt_s = LOCK;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        locked_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      en_q_r   <= 1'b0;
      cand_r   <= 3'd0;
      mcnt_r   <= 4'd0;
      sw_det_r <= 3'd0;
      locked_r <= 1'b0;
      err_r    <= 1'b0;
      q_r      <= 4'd0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      en_q_r   <= en;
      cand_r   <= cand_nxt_s;
      mcnt_r   <= mcnt_nxt_s;
      sw_det_r <= sw_det_nxt_s;
      locked_r <= locked_nxt_s;
      err_r    <= err_nxt_s;
      q_r      <= q_nxt_s;
    end
  end

endmodule

// File: tb/tb_period_detector.sv
// Self-checking bench for period_detector (BASE_DIV=4, LOCK_N=2, CNT_W=12).
module tb_period_detector;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] sw_det;
  logic       locked;
  logic       err;
  logic [3:0] q;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit         rst;   // pulse reset before this record
    int         idle;  // en-low cycles before the pulse
    bit         lk;
    bit         er;
    logic [2:0] sw;
    logic [3:0] qq;
  } vec_t;

  vec_t tbl[$];

  period_detector #(
    .BASE_DIV(4),
    .LOCK_N  (2),
    .CNT_W   (12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .sw_det(sw_det),
    .locked(locked),
    .err   (err),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic v);
    en = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int idle);
    for (int c = 0; c < idle; c++) step(1'b0);
    step(1'b1);
  endtask

  task automatic chk1(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input bit lk, input bit er,
                         input logic [2:0] sw, input logic [3:0] qq);
    chk1({nm, ".locked"}, {7'd0, locked}, {7'd0, lk});
    chk1({nm, ".err"},    {7'd0, err},    {7'd0, er});
    chk1({nm, ".sw_det"}, {5'd0, sw_det}, {5'd0, sw});
    chk1({nm, ".q"},      {4'd0, q},      {4'd0, qq});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
  endtask

  task automatic add(input bit rst, input int idle, input bit lk, input bit er,
                     input logic [2:0] sw, input logic [3:0] qq);
    vec_t v;
    v.rst  = rst;
    v.idle = idle;
    v.lk   = lk;
    v.er   = er;
    v.sw   = sw;
    v.qq   = qq;
    tbl.push_back(v);
  endtask

  initial begin
    bit         plk;
    logic [2:0] psw;
    logic [3:0] pq;

    reset = 1'b1;
    en    = 1'b0;
    step(1'b0);
    chk_all("reset", 1'b0, 1'b0, 3'd0, 4'd0);
    step(1'b0);
    reset = 1'b0;

    // Period 4: lock on 3rd pulse, then q steps 1..15 and wraps to 0.
    add(1'b1, 3, 1'b0, 1'b0, 3'd0, 4'd0);
    add(1'b0, 3, 1'b0, 1'b0, 3'd0, 4'd0);
    add(1'b0, 3, 1'b1, 1'b0, 3'd0, 4'd0);
    for (int i = 1; i <= 16; i++) add(1'b0, 3, 1'b1, 1'b0, 3'd0, 4'(i % 16));
    // Two more at period 4, then switch to period 8.
    add(1'b0, 3, 1'b1, 1'b0, 3'd0, 4'd1);
    add(1'b0, 3, 1'b1, 1'b0, 3'd0, 4'd2);
    add(1'b0, 7, 1'b0, 1'b1, 3'd0, 4'd2);
    add(1'b0, 7, 1'b1, 1'b0, 3'd1, 4'd0);
    // Period 32 -> code 3.
    add(1'b1, 3,  1'b0, 1'b0, 3'd0, 4'd0);
    add(1'b0, 31, 1'b0, 1'b0, 3'd0, 4'd0);
    add(1'b0, 31, 1'b1, 1'b0, 3'd3, 4'd0);
    add(1'b0, 31, 1'b1, 1'b0, 3'd3, 4'd1);
    // Period 5 never matches: err on each pulse after the first.
    add(1'b1, 3, 1'b0, 1'b0, 3'd0, 4'd0);
    for (int i = 0; i < 4; i++) add(1'b0, 4, 1'b0, 1'b1, 3'd0, 4'd0);

    plk = 1'b0;
    psw = 3'd0;
    pq  = 4'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset();
        plk = 1'b0;
        psw = 3'd0;
        pq  = 4'd0;
      end
      for (int c = 0; c < tbl[i].idle; c++) begin
        step(1'b0);
        chk_all($sformatf("v%0d.gap", i), plk, 1'b0, psw, pq);
      end
      step(1'b1);
      chk_all($sformatf("v%0d", i), tbl[i].lk, tbl[i].er, tbl[i].sw, tbl[i].qq);
      plk = tbl[i].lk;
      psw = tbl[i].sw;
      pq  = tbl[i].qq;
    end

    // Timeout: locked at code 0, en low; err fires on the 513th edge after the pulse.
    do_reset();
    pulse(3);
    pulse(3);
    pulse(3);
    chk_all("to.lock", 1'b1, 1'b0, 3'd0, 4'd0);
    for (int c = 0; c < 512; c++) begin
      step(1'b0);
      chk1("to.quiet", {7'd0, err}, 8'd0);
    end
    chk_all("to.pre", 1'b1, 1'b0, 3'd0, 4'd0);
    step(1'b0);
    chk_all("to.fire", 1'b0, 1'b1, 3'd0, 4'd0);
    step(1'b0);
    chk_all("to.after", 1'b0, 1'b0, 3'd0, 4'd0);

    // en held high from IDLE: a single edge. Its timing is proven by a
    // follow-up pulse 128 cycles after it (code 5) being accepted without err.
    for (int c = 0; c < 100; c++) begin
      step(1'b1);
      chk1("hold.err", {7'd0, err}, 8'd0);
      chk1("hold.locked", {7'd0, locked}, 8'd0);
    end
    for (int c = 0; c < 28; c++) begin
      step(1'b0);
      chk1("hold.low.err", {7'd0, err}, 8'd0);
    end
    step(1'b1);
    chk_all("hold.p128", 1'b0, 1'b0, 3'd0, 4'd0);
    pulse(127);
    chk_all("hold.lock", 1'b1, 1'b0, 3'd5, 4'd0);

    // Asynchronous reset while locked at code 2 with q=5.
    do_reset();
    pulse(3);
    pulse(15);
    pulse(15);
    chk_all("r.lock", 1'b1, 1'b0, 3'd2, 4'd0);
    for (int c = 0; c < 5; c++) pulse(15);
    chk_all("r.q5", 1'b1, 1'b0, 3'd2, 4'd5);
    #2 reset = 1'b1;
    #1 chk_all("r.async", 1'b0, 1'b0, 3'd0, 4'd0);
    #1 reset = 1'b0;
    pulse(3);
    chk_all("r.p1", 1'b0, 1'b0, 3'd0, 4'd0);
    pulse(15);
    chk_all("r.p2", 1'b0, 1'b0, 3'd0, 4'd0);
    pulse(15);
    chk_all("r.p3", 1'b1, 1'b0, 3'd2, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
